// File: rtl/spi_9952_pkg.sv
// Shared definitions for the AD9952 serial-port responder: register map, widths,
// reset values, FSM state encoding and the per-address transfer length.
package spi_9952_pkg;

    localparam logic [4:0] ADDR_CFR1 = 5'h00;
    localparam logic [4:0] ADDR_CFR2 = 5'h01;
    localparam logic [4:0] ADDR_ASF  = 5'h02;
    localparam logic [4:0] ADDR_ARR  = 5'h03;
    localparam logic [4:0] ADDR_FTW0 = 5'h04;
    localparam logic [4:0] ADDR_POW0 = 5'h05;

    localparam int CFR1_W = 32;
    localparam int CFR2_W = 24;
    localparam int ASF_W  = 16;
    localparam int ARR_W  = 8;
    localparam int FTW0_W = 32;
    localparam int POW0_W = 16;
    localparam int ERR_W  = 8;

    localparam logic [CFR1_W-1:0] CFR1_RST = '0;
    localparam logic [CFR2_W-1:0] CFR2_RST = '0;
    localparam logic [ASF_W-1:0]  ASF_RST  = '0;
    localparam logic [ARR_W-1:0]  ARR_RST  = '0;
    localparam logic [FTW0_W-1:0] FTW0_RST = '0;
    localparam logic [POW0_W-1:0] POW0_RST = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INSTR,
        S_DATA,
        S_DRAIN
    } state_t;

    // Unmapped addresses still clock four bytes so the master's framing stays intact.
    function automatic logic [2:0] reg_len(input logic [4:0] addr);
        case (addr)
            ADDR_CFR1: reg_len = 3'd4;
            ADDR_CFR2: reg_len = 3'd3;
            ADDR_ASF:  reg_len = 3'd2;
            ADDR_ARR:  reg_len = 3'd1;
            ADDR_FTW0: reg_len = 3'd4;
            ADDR_POW0: reg_len = 3'd2;
            default:   reg_len = 3'd4;
        endcase
    endfunction

    function automatic logic is_mapped(input logic [4:0] addr);
        is_mapped = (addr <= ADDR_POW0);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by one history
// flop that yields single-clk rise and fall strobes.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_9952.sv
// AD9952 serial-port responder: instruction/data decode, shadow and active banks,
// io_update commit and miso readback. Define SPI_SLAVE_9952_ERRCNT_EN for err_cnt.
module spi_slave_9952
    import spi_9952_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sclk,
    input  logic              n_cs,
    input  logic              mosi,
    input  logic              io_update,
    output logic              miso,
    output logic              miso_oe,
    output logic              upd_pulse,
    output logic [CFR1_W-1:0] cfr1,
    output logic [CFR2_W-1:0] cfr2,
    output logic [ASF_W-1:0]  asf,
    output logic [ARR_W-1:0]  arr,
    output logic [FTW0_W-1:0] ftw0,
    output logic [POW0_W-1:0] pow0
`ifdef SPI_SLAVE_9952_ERRCNT_EN
    ,
    output logic [ERR_W-1:0]  err_cnt
`endif
);

    logic sclk_rise, sclk_fall, cs_lvl, cs_fall, mosi_lvl, upd_rise;
    logic sclk_lvl_unused, cs_rise_unused, mosi_rise_unused, mosi_fall_unused;
    logic upd_lvl_unused, upd_fall_unused;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .n_rst(n_rst), .din(sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .n_rst(n_rst), .din(n_cs),
        .level(cs_lvl), .rise(cs_rise_unused), .fall(cs_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .n_rst(n_rst), .din(mosi),
        .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_upd (
        .clk(clk), .n_rst(n_rst), .din(io_update),
        .level(upd_lvl_unused), .rise(upd_rise), .fall(upd_fall_unused)
    );

    state_t      state, state_nxt;
    logic [2:0]  bit_cnt, byte_cnt, len;
    logic [6:0]  instr_sh;
    logic [7:0]  instr_full;
    logic        rd;
    logic [4:0]  addr;
    logic [31:0] acc, out_sh, rd_word;
    logic        wr_pend;
    logic        abort, decode, byte_done, last_byte;

    logic [CFR1_W-1:0] sh_cfr1;
    logic [CFR2_W-1:0] sh_cfr2;
    logic [ASF_W-1:0]  sh_asf;
    logic [ARR_W-1:0]  sh_arr;
    logic [FTW0_W-1:0] sh_ftw0;
    logic [POW0_W-1:0] sh_pow0;

    assign instr_full = {instr_sh, mosi_lvl};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Chip-select release overrides everything, so a torn transfer never reaches DATA/DRAIN logic.
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        decode    = 1'b0;
        byte_done = 1'b0;
        last_byte = 1'b0;
        if (state != S_IDLE && cs_lvl) begin
            abort     = 1'b1;
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cs_fall) state_nxt = S_INSTR;
                end
                S_INSTR: begin
                    if (sclk_rise && bit_cnt == 3'd7) begin
                        decode    = 1'b1;
                        state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    if (sclk_rise && bit_cnt == 3'd7) begin
                        byte_done = 1'b1;
                        if (byte_cnt + 3'd1 == len) begin
                            last_byte = 1'b1;
                            state_nxt = S_DRAIN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Readback is taken from the active bank, left-justified so bit 31 leaves first.
    always_comb begin
        rd_word = '0;
        case (instr_full[4:0])
            ADDR_CFR1: rd_word = cfr1;
            ADDR_CFR2: rd_word = {cfr2, 8'h00};
            ADDR_ASF:  rd_word = {asf, 16'h0000};
            ADDR_ARR:  rd_word = {arr, 24'h000000};
            ADDR_FTW0: rd_word = ftw0;
            ADDR_POW0: rd_word = {pow0, 16'h0000};
            default:   rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            len      <= '0;
            instr_sh <= '0;
            rd       <= 1'b0;
            addr     <= '0;
            acc      <= '0;
            out_sh   <= '0;
            wr_pend  <= 1'b0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            if (abort) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
                miso     <= 1'b0;
                miso_oe  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cs_fall) begin
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                        end
                    end
                    S_INSTR: begin
                        if (sclk_rise) begin
                            instr_sh <= instr_full[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                        end
                        if (decode) begin
                            rd       <= instr_full[7];
                            addr     <= instr_full[4:0];
                            len      <= reg_len(instr_full[4:0]);
                            byte_cnt <= '0;
                            acc      <= '0;
                            out_sh   <= instr_full[7] ? rd_word : 32'h0;
                        end
                    end
                    S_DATA: begin
                        if (sclk_rise) begin
                            acc     <= {acc[30:0], mosi_lvl};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (byte_done) byte_cnt <= byte_cnt + 3'd1;
                        // The final register bit is already in acc, so the shadow write can follow next clk.
                        if (last_byte) begin
                            miso    <= 1'b0;
                            miso_oe <= 1'b0;
                            wr_pend <= !rd && is_mapped(addr);
                        end else if (sclk_fall && rd) begin
                            miso    <= out_sh[31];
                            out_sh  <= {out_sh[30:0], 1'b0};
                            miso_oe <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A commit and a shadow write on the same clk: active takes the old shadow value.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sh_cfr1   <= CFR1_RST;
            sh_cfr2   <= CFR2_RST;
            sh_asf    <= ASF_RST;
            sh_arr    <= ARR_RST;
            sh_ftw0   <= FTW0_RST;
            sh_pow0   <= POW0_RST;
            cfr1      <= CFR1_RST;
            cfr2      <= CFR2_RST;
            asf       <= ASF_RST;
            arr       <= ARR_RST;
            ftw0      <= FTW0_RST;
            pow0      <= POW0_RST;
            upd_pulse <= 1'b0;
        end else begin
            upd_pulse <= upd_rise;
            if (upd_rise) begin
                cfr1 <= sh_cfr1;
                cfr2 <= sh_cfr2;
                asf  <= sh_asf;
                arr  <= sh_arr;
                ftw0 <= sh_ftw0;
                pow0 <= sh_pow0;
            end
            if (wr_pend) begin
                case (addr)
                    ADDR_CFR1: sh_cfr1 <= acc;
                    ADDR_CFR2: sh_cfr2 <= acc[CFR2_W-1:0];
                    ADDR_ASF:  sh_asf  <= acc[ASF_W-1:0];
                    ADDR_ARR:  sh_arr  <= acc[ARR_W-1:0];
                    ADDR_FTW0: sh_ftw0 <= acc;
                    ADDR_POW0: sh_pow0 <= acc[POW0_W-1:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_9952_ERRCNT_EN
    logic err_evt;

    assign err_evt = (abort && (state == S_INSTR || state == S_DATA || bit_cnt != 3'd0)) ||
                     (decode && !instr_full[7] && !is_mapped(instr_full[4:0]));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_cnt <= '0;
        end else if (err_evt && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_9952.sv
// Randomized self-checking bench for spi_slave_9952 against a register-map level
// model of shadow/active banks, readback and (optionally) the error counter.
module tb_spi_slave_9952;

    logic        clk, n_rst, sclk, n_cs, mosi, io_update;
    logic        miso, miso_oe, upd_pulse;
    logic [31:0] cfr1;
    logic [23:0] cfr2;
    logic [15:0] asf;
    logic [7:0]  arr;
    logic [31:0] ftw0;
    logic [15:0] pow0;
`ifdef SPI_SLAVE_9952_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    spi_slave_9952 #(.SYNC_STAGES(2)) dut (
        .clk(clk), .n_rst(n_rst), .sclk(sclk), .n_cs(n_cs), .mosi(mosi),
        .io_update(io_update), .miso(miso), .miso_oe(miso_oe), .upd_pulse(upd_pulse),
        .cfr1(cfr1), .cfr2(cfr2), .asf(asf), .arr(arr), .ftw0(ftw0), .pow0(pow0)
`ifdef SPI_SLAVE_9952_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  tx_bytes [0:7];
    logic        rx_bits  [0:63];
    logic        rx_oe    [0:63];
    logic [31:0] sh_m     [0:5];
    logic [31:0] act_m    [0:5];
    int          err_m;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int lenOf(input logic [4:0] a);
        case (a)
            5'd0: return 4;
            5'd1: return 3;
            5'd2: return 2;
            5'd3: return 1;
            5'd4: return 4;
            5'd5: return 2;
            default: return 4;
        endcase
    endfunction

    task automatic errInc();
        if (err_m < 255) err_m++;
    endtask

    task automatic modelReset();
        for (int k = 0; k < 6; k++) begin
            sh_m[k]  = '0;
            act_m[k] = '0;
        end
        err_m = 0;
    endtask

    task automatic loadTx(input logic [55:0] b);
        for (int k = 0; k < 7; k++) tx_bytes[k] = b[55-8*k -: 8];
        tx_bytes[7] = 8'h00;
    endtask

    // One framed transfer of nbits; miso is sampled just before each sclk rise.
    task automatic applyStimulus(input int nbits, input int rst_at);
        @(negedge clk);
        n_cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx_bytes[i/8][7 - (i % 8)];
            repeat (4) @(negedge clk);
            rx_bits[i] = miso;
            rx_oe[i]   = miso_oe;
            if (rst_at == i) begin
                #2 n_rst = 1'b0;
                return;
            end
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        n_cs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, "_cfr1"}, cfr1, act_m[0]);
        checkOutput({tag, "_cfr2"}, {8'h00, cfr2}, act_m[1]);
        checkOutput({tag, "_asf"},  {16'h0, asf}, act_m[2]);
        checkOutput({tag, "_arr"},  {24'h0, arr}, act_m[3]);
        checkOutput({tag, "_ftw0"}, ftw0, act_m[4]);
        checkOutput({tag, "_pow0"}, {16'h0, pow0}, act_m[5]);
`ifdef SPI_SLAVE_9952_ERRCNT_EN
        checkOutput({tag, "_err_cnt"}, {24'h0, err_cnt}, err_m);
`endif
    endtask

    task automatic checkTransaction(input string tag, input int nbits);
        logic [7:0]  ins;
        logic [4:0]  a;
        logic [31:0] word, obs, expv;
        int len, full, nd, oe_hi, leak;
        ins  = tx_bytes[0];
        a    = ins[4:0];
        len  = lenOf(a);
        full = 8 + 8 * len;
        if (nbits >= 8 && !ins[7] && a > 5) errInc();
        if (nbits < full) begin
            errInc();
        end else if (!ins[7] && a <= 5) begin
            word = '0;
            for (int k = 1; k <= len; k++) word = (word << 8) | {24'h0, tx_bytes[k]};
            sh_m[a] = word;
        end
        oe_hi = 0;
        leak  = 0;
        for (int i = 0; i < nbits; i++) begin
            if (rx_oe[i]) oe_hi++;
            else if (rx_bits[i]) leak++;
        end
        nd = ((nbits < full) ? nbits : full) - 8;
        if (nd < 0 || !ins[7]) nd = 0;
        checkOutput({tag, "_oe_bits"}, oe_hi, nd);
        checkOutput({tag, "_miso_idle"}, leak, 0);
        if (nd > 0) begin
            word = (a <= 5) ? act_m[a] : 32'h0;
            obs  = '0;
            expv = '0;
            for (int j = 0; j < nd; j++) begin
                obs  = {obs[30:0], rx_bits[8+j]};
                expv = {expv[30:0], word[8*len-1-j]};
            end
            checkOutput({tag, "_rdata"}, obs, expv);
        end
        checkRegs(tag);
    endtask

    task automatic pulseIoUpdate(input string tag);
        int pulses;
        pulses = 0;
        @(negedge clk);
        io_update = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (upd_pulse) pulses++;
        end
        io_update = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (upd_pulse) pulses++;
        end
        checkOutput({tag, "_upd_pulses"}, pulses, 1);
        for (int k = 0; k < 6; k++) act_m[k] = sh_m[k];
        checkRegs(tag);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_miso"}, {31'h0, miso}, 0);
        checkOutput({tag, "_miso_oe"}, {31'h0, miso_oe}, 0);
        checkOutput({tag, "_upd_pulse"}, {31'h0, upd_pulse}, 0);
        checkRegs(tag);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int nbits, len, extra;
        logic [4:0] a;
        n_rst = 1'b0; sclk = 1'b0; n_cs = 1'b1; mosi = 1'b0; io_update = 1'b0;
        modelReset();
        for (int k = 0; k < 8; k++) tx_bytes[k] = 8'h00;
        repeat (4) @(negedge clk);
        checkResetState("reset");
        n_rst = 1'b1;
        repeat (10) @(negedge clk);

        loadTx({8'h04, 32'h12345678, 16'h0});
        applyStimulus(40, -1);
        checkTransaction("ftw0_wr", 40);
        pulseIoUpdate("ftw0_upd");
        checkOutput("ftw0_value", ftw0, 32'h12345678);

        loadTx({8'h02, 16'h3FFF, 32'h0});
        applyStimulus(24, -1);
        checkTransaction("asf_wr", 24);
        loadTx({8'h82, 48'h0});
        applyStimulus(24, -1);
        checkTransaction("asf_rd_old", 24);
        pulseIoUpdate("asf_upd");
        applyStimulus(24, -1);
        checkTransaction("asf_rd_new", 24);
        checkOutput("asf_value", {16'h0, asf}, 32'h3FFF);

        loadTx({8'h01, 40'hAABBCCDDEE, 8'h0});
        applyStimulus(48, -1);
        checkTransaction("cfr2_long", 48);
        pulseIoUpdate("cfr2_upd");
        checkOutput("cfr2_value", {8'h0, cfr2}, 32'hAABBCC);

        loadTx({8'h05, 16'h1122, 32'h0});
        applyStimulus(19, -1);
        checkTransaction("pow0_cut", 19);
        pulseIoUpdate("pow0_upd");
        checkOutput("pow0_value", {16'h0, pow0}, 32'h0);

        loadTx({8'h84, 48'h0});
        applyStimulus(40, 14);
        checkOutput("rst_oe_before", {31'h0, rx_oe[14]}, 1);
        #1;
        modelReset();
        checkResetState("rst_mid_read");
        n_cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (10) @(negedge clk);

        loadTx({8'h03, 8'h5A, 40'h0});
        applyStimulus(16, -1);
        checkTransaction("arr_wr", 16);
        pulseIoUpdate("arr_upd");
        checkOutput("arr_value", {24'h0, arr}, 32'h5A);

        for (int t = 0; t < 40; t++) begin
            a = 5'($urandom_range(0, 7));
            tx_bytes[0] = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a};
            for (int k = 1; k < 8; k++) tx_bytes[k] = 8'($urandom);
            len   = lenOf(a);
            extra = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) nbits = $urandom_range(1, 8 + 8 * len - 1);
            else nbits = 8 + 8 * (len + extra);
            applyStimulus(nbits, -1);
            checkTransaction("rand", nbits);
            if ($urandom_range(0, 1) == 1) pulseIoUpdate("rand_upd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
